bike_orient_ctrl: RTL and testbench
===================================

// Module: bike_orient_ctrl
// PURPOSE
//  Player-input front end that drives the regfile orientation write ports (bike*Orient_IN).
//  Debounces four players' direction buttons and applies turn rules: one turn per press, no 180-degree reversal.
//  Emits new 32-bit orientation words plus a one-cycle update strobe per bike.
//  Sits between the board buttons and the decode-stage regfile; it reads the current orientation back from bike*Orient.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  consecutive high cycles before a button counts as pressed (>=2)
//  LOCKOUT_CYCLES   1000000  post-turn lockout length; used only with ORIENT_LOCKOUT_EN
//  INIT_ONE/TWO/THREE/FOUR  1/3/2/0  reset orientation per bike (0=up,1=right,2=down,3=left)
// PORTS
//  clock              in   1   system clock, rising edge
//  reset              in   1   asynchronous, active-high
//  masterSwitch       in   1   1=game running, inputs accepted; 0=inputs ignored
//  btn_one..btn_four  in   4   raw buttons per bike {left,down,right,up}, active-high, asynchronous
//  bikeoneOrient..bikefourOrient  in 32  current orientation from regfile; only [1:0] used
//  bikeoneOrient_IN..bikefourOrient_IN  out 32  requested orientation, zero-extended 2-bit code
//  orient_upd         out  4   [0]=bike one..[3]=bike four; 1-cycle pulse when that *_IN changes
// BEHAVIOUR
//  - Reset (async assert): *_IN = INIT_* zero-extended, orient_upd=0, all debounce/lockout counters 0,
//    debounced levels 0. Release is synchronised to clock; first accept is possible no earlier than
//    DEBOUNCE_CYCLES+3 cycles after deassert.
//  - Input sync: each button passes a 2-flop synchroniser before debounce.
//  - Debounce, per button: counter increments while the synced level is 1 and saturates at DEBOUNCE_CYCLES;
//    a 0 clears it. Debounced level = (count==DEBOUNCE_CYCLES).
//  - A press event is the rising edge of the debounced level. One event per press; holding the button
//    gives no repeats.
//  - Same-cycle events on one bike: priority up>right>down>left; the other events are discarded.
//  - Accept rule for candidate dir d against cur=bike*Orient[1:0]:
//    - reject if d==cur (no change);
//    - reject if d==cur^2 (reversal);
//    - reject if masterSwitch==0;
//    - otherwise register *_IN<=d and pulse orient_upd[i] in the next cycle.
//  - Latency: 1 clock from the debounced rising edge to the *_IN/orient_upd register update.
//  - *_IN holds its value between accepts. It is not cleared on reject or when masterSwitch goes low.
//  - The four bikes are fully independent. Simultaneous accepts on all four are legal and pulse all
//    orient_upd bits together.
//  - If the regfile has not yet written back, cur is stale. The rule is checked against cur as presented;
//    no internal shadow is used.
//  - reset mid-debounce or mid-lockout: everything returns to reset state immediately; no event survives.
//  - Bits [31:2] of *_IN are always 0.
// CONFIGURATION
//  ORIENT_LOCKOUT_EN defined:
//    - after an accept on bike i, further events on bike i are discarded for LOCKOUT_CYCLES clocks;
//    - the per-bike counter loads on accept, counts down to 0, and is cleared by reset;
//    - masterSwitch low does not pause the counter.
//  ORIENT_LOCKOUT_EN undefined:
//    - no lockout logic; any legal event is accepted.
// TESTING
//  (bench: DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8, masterSwitch=1 unless stated)
//  T1 reset: assert reset with buttons toggling -> *_IN = 1,3,2,0 and orient_upd=0 during and after reset.
//  T2 turn: bike one cur=1, hold btn_one=4'b0100 (down) for 10 cycles -> exactly one orient_upd[0] pulse,
//     bikeoneOrient_IN=2, produced 4 synced-high cycles + 1 after the synchronised edge.
//  T3 reversal: bike two cur=3, press right (4'b0010) -> no pulse, bikeonetwoOrient_IN stays 3;
//     then press up -> becomes 0.
//  T4 bounce/priority: glitch up for 3 cycles -> no event; press up+left together on bike three (cur=1)
//     -> Orient_IN=0 only.
//  T5 gating: masterSwitch=0, press down on bike four (cur=0... use cur=1) -> no change; raise
//     masterSwitch mid-hold -> no event until release and re-press.
//  T6 ORIENT_LOCKOUT_EN: two legal presses on bike one 5 cycles apart -> second ignored;
//     repeat 10 cycles apart -> both accepted. Without macro, both accepted in each case.

Source files
------------

// File: rtl/bike_orient_ctrl.sv
// bike_orient_ctrl: player-input front end for the four bike orientation write ports.
//   Synchronises and debounces each player's direction buttons, turns the rising edge of a
//   debounced level into a single turn request, and accepts it unless it is a no-op, a 180-degree
//   reversal, or the game is halted. Accepted turns are registered onto bike*Orient_IN with a
//   one-cycle orient_upd strobe.
// Optional build macro: ORIENT_LOCKOUT_EN adds a per-bike post-turn lockout of LOCKOUT_CYCLES.
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   masterSwitch                 1 = game running, turns accepted
//   btn_one..btn_four [3:0]      raw buttons {left,down,right,up}, asynchronous
//   bike*Orient [31:0]           current orientation from the regfile ([1:0] used)
//   bike*Orient_IN [31:0]        requested orientation, zero-extended 2-bit code
//   orient_upd [3:0]             one-cycle pulse per bike when its *_IN is rewritten
module bike_orient_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned LOCKOUT_CYCLES  = 1000000,
  parameter logic [1:0]  INIT_ONE        = 2'd1,
  parameter logic [1:0]  INIT_TWO        = 2'd3,
  parameter logic [1:0]  INIT_THREE      = 2'd2,
  parameter logic [1:0]  INIT_FOUR       = 2'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        masterSwitch,
  input  logic [3:0]  btn_one,
  input  logic [3:0]  btn_two,
  input  logic [3:0]  btn_three,
  input  logic [3:0]  btn_four,
  input  logic [31:0] bikeoneOrient,
  input  logic [31:0] biketwoOrient,
  input  logic [31:0] bikethreeOrient,
  input  logic [31:0] bikefourOrient,
  output logic [31:0] bikeoneOrient_IN,
  output logic [31:0] biketwoOrient_IN,
  output logic [31:0] bikethreeOrient_IN,
  output logic [31:0] bikefourOrient_IN,
  output logic [3:0]  orient_upd
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DebMax = DW'(DEBOUNCE_CYCLES);
  localparam logic [7:0] InitPack = {INIT_FOUR, INIT_THREE, INIT_TWO, INIT_ONE};

  logic [3:0] btn_raw [4];
  logic [1:0] cur     [4];

  assign btn_raw[0] = btn_one;
  assign btn_raw[1] = btn_two;
  assign btn_raw[2] = btn_three;
  assign btn_raw[3] = btn_four;
  assign cur[0]     = bikeoneOrient[1:0];
  assign cur[1]     = biketwoOrient[1:0];
  assign cur[2]     = bikethreeOrient[1:0];
  assign cur[3]     = bikefourOrient[1:0];

  logic unused_orient_hi;
  assign unused_orient_hi = ^{bikeoneOrient[31:2], biketwoOrient[31:2],
                              bikethreeOrient[31:2], bikefourOrient[31:2]};

  // Reset asserts immediately but releases two clocks later, aligned to the clock.
  logic [1:0] rst_sync_q;
  logic       rst_int;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_int = rst_sync_q[1];

  logic [3:0]    sync1_q    [4];
  logic [3:0]    sync2_q    [4];
  logic [DW-1:0] deb_cnt_q  [4][4];
  logic [DW-1:0] deb_cnt_d  [4][4];
  logic [3:0]    deb_lvl    [4];
  logic [3:0]    deb_prev_q [4];
  logic [1:0]    orient_q   [4];
  logic [1:0]    orient_d   [4];
  logic [3:0]    upd_q;
  logic [3:0]    upd_d;

`ifdef ORIENT_LOCKOUT_EN
  localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LW-1:0] LockMax = LW'(LOCKOUT_CYCLES);
  logic [LW-1:0] lock_q [4];
  logic [LW-1:0] lock_d [4];
`endif

  always_comb begin
    upd_d = '0;
    for (int b = 0; b < 4; b++) begin
      logic [3:0] evt;
      logic [1:0] dir;
      logic       accept;
      deb_lvl[b]  = '0;
      orient_d[b] = orient_q[b];
      for (int k = 0; k < 4; k++) begin
        deb_lvl[b][k] = (deb_cnt_q[b][k] == DebMax);
        if (!sync2_q[b][k])     deb_cnt_d[b][k] = '0;
        else if (deb_lvl[b][k]) deb_cnt_d[b][k] = deb_cnt_q[b][k];
        else                    deb_cnt_d[b][k] = deb_cnt_q[b][k] + DW'(1);
      end
      evt = deb_lvl[b] & ~deb_prev_q[b];
`ifdef ORIENT_LOCKOUT_EN
      lock_d[b] = (lock_q[b] != '0) ? lock_q[b] - LW'(1) : '0;
      if (lock_q[b] != '0) evt = '0;
`endif
      // Bit index equals direction code; lowest set bit wins (up > right > down > left).
      dir = 2'd0;
      for (int k = 3; k >= 0; k--) begin
        if (evt[k]) dir = 2'(k);
      end
      accept = (evt != '0) && masterSwitch && (dir != cur[b]) && (dir != (cur[b] ^ 2'd2));
      if (accept) begin
        orient_d[b] = dir;
        upd_d[b]    = 1'b1;
`ifdef ORIENT_LOCKOUT_EN
        lock_d[b]   = LockMax;
`endif
      end
    end
  end

  always_ff @(posedge clock or posedge rst_int) begin
    if (rst_int) begin
      upd_q <= '0;
      for (int b = 0; b < 4; b++) begin
        sync1_q[b]    <= '0;
        sync2_q[b]    <= '0;
        deb_prev_q[b] <= '0;
        orient_q[b]   <= InitPack[2*b +: 2];
`ifdef ORIENT_LOCKOUT_EN
        lock_q[b]     <= '0;
`endif
        for (int k = 0; k < 4; k++) deb_cnt_q[b][k] <= '0;
      end
    end else begin
      upd_q <= upd_d;
      for (int b = 0; b < 4; b++) begin
        sync1_q[b]    <= btn_raw[b];
        sync2_q[b]    <= sync1_q[b];
        deb_prev_q[b] <= deb_lvl[b];
        orient_q[b]   <= orient_d[b];
`ifdef ORIENT_LOCKOUT_EN
        lock_q[b]     <= lock_d[b];
`endif
        for (int k = 0; k < 4; k++) deb_cnt_q[b][k] <= deb_cnt_d[b][k];
      end
    end
  end

  assign bikeoneOrient_IN   = {30'd0, orient_q[0]};
  assign biketwoOrient_IN   = {30'd0, orient_q[1]};
  assign bikethreeOrient_IN = {30'd0, orient_q[2]};
  assign bikefourOrient_IN  = {30'd0, orient_q[3]};
  assign orient_upd         = upd_q;

endmodule

// File: tb/tb_bike_orient_ctrl.sv
// Directed bench for bike_orient_ctrl with DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8.
module tb_bike_orient_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        masterSwitch;
  logic [3:0]  btn_one, btn_two, btn_three, btn_four;
  logic [31:0] cur1, cur2, cur3, cur4;
  logic [31:0] in1, in2, in3, in4;
  logic [3:0]  orient_upd;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  bike_orient_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .LOCKOUT_CYCLES (8)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .masterSwitch      (masterSwitch),
    .btn_one           (btn_one),
    .btn_two           (btn_two),
    .btn_three         (btn_three),
    .btn_four          (btn_four),
    .bikeoneOrient     (cur1),
    .biketwoOrient     (cur2),
    .bikethreeOrient   (cur3),
    .bikefourOrient    (cur4),
    .bikeoneOrient_IN  (in1),
    .biketwoOrient_IN  (in2),
    .bikethreeOrient_IN(in3),
    .bikefourOrient_IN (in4),
    .orient_upd        (orient_upd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_btn(input int b, input logic [3:0] pat);
    case (b)
      0: btn_one   = pat;
      1: btn_two   = pat;
      2: btn_three = pat;
      default: btn_four = pat;
    endcase
  endtask

  // Holds a pattern for 'hold' cycles, releases, then idles 8 cycles; counts strobe pulses.
  task automatic run_press(input int b, input logic [3:0] pat, input int hold,
                           output int pulses, output int first);
    pulses = 0;
    first  = 0;
    set_btn(b, pat);
    for (int i = 1; i <= hold + 8; i++) begin
      if (i == hold + 1) set_btn(b, 4'b0000);
      @(negedge clock);
      if (orient_upd[b]) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
  endtask

  task automatic do_reset();
    btn_one = '0; btn_two = '0; btn_three = '0; btn_four = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  // Bike one from cur=1: down, then left 'gap' cycles later; regfile write-back after the first.
  task automatic lock_pair(input int gap, input int exp_pulses, input logic [31:0] exp_in,
                           input string tag);
    int pulses;
    do_reset();
    cur1 = 32'd1;
    pulses = 0;
    btn_one = 4'b0100;
    for (int i = 1; i <= 25; i++) begin
      if (i == gap + 1) btn_one = 4'b1100;
      @(negedge clock);
      if (orient_upd[0]) begin
        pulses++;
        cur1 = {30'd0, in1[1:0]};
      end
    end
    btn_one = 4'b0000;
    repeat (10) @(negedge clock);
    check({tag, "_pulses"}, pulses, exp_pulses);
    check({tag, "_in"}, in1, exp_in);
  endtask

  initial begin
    int pulses, first, nz, upd_seen, upd_cycle;
    masterSwitch = 1'b1;
    cur1 = 32'd1; cur2 = 32'd3; cur3 = 32'd1; cur4 = 32'd1;
    reset = 1'b1;
    btn_one = '0; btn_two = '0; btn_three = '0; btn_four = '0;

    // T1: reset with buttons toggling
    nz = 0;
    for (int i = 0; i < 12; i++) begin
      btn_one = 4'(i); btn_two = 4'(~i); btn_three = 4'b1111; btn_four = 4'(i * 3);
      @(negedge clock);
      if (orient_upd != 4'b0000) nz++;
    end
    check("rst_upd_during", nz, 0);
    check("rst_in1", in1, 32'd1);
    check("rst_in2", in2, 32'd3);
    check("rst_in3", in3, 32'd2);
    check("rst_in4", in4, 32'd0);
    btn_one = '0; btn_two = '0; btn_three = '0; btn_four = '0;
    reset = 1'b0;
    nz = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (orient_upd != 4'b0000) nz++;
    end
    check("rst_upd_after", nz, 0);
    check("rst_in1_after", in1, 32'd1);

    // T2: bike one cur=1, press down: 2 sync + 4 debounce + 1 register = cycle 7
    run_press(0, 4'b0100, 10, pulses, first);
    check("t2_pulses", pulses, 1);
    check("t2_latency", first, 7);
    check("t2_in1", in1, 32'd2);
    cur1 = 32'd2;

    // T3: reversal on bike two rejected, then a legal turn
    run_press(1, 4'b0010, 10, pulses, first);
    check("t3_rev_pulses", pulses, 0);
    check("t3_rev_in2", in2, 32'd3);
    run_press(1, 4'b0001, 10, pulses, first);
    check("t3_up_pulses", pulses, 1);
    check("t3_up_in2", in2, 32'd0);
    cur2 = 32'd0;

    // T4: 3-cycle glitch is not a press; up+left together resolves to up
    run_press(2, 4'b0001, 3, pulses, first);
    check("t4_glitch_pulses", pulses, 0);
    check("t4_glitch_in3", in3, 32'd2);
    run_press(2, 4'b1001, 10, pulses, first);
    check("t4_prio_pulses", pulses, 1);
    check("t4_prio_in3", in3, 32'd0);
    cur3 = 32'd0;

    // Same-direction request is a no-op
    run_press(2, 4'b0001, 10, pulses, first);
    check("same_dir_pulses", pulses, 0);

    // T5: gating, then raise masterSwitch mid-hold, then re-press
    masterSwitch = 1'b0;
    btn_four = 4'b0100;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) masterSwitch = 1'b1;
      @(negedge clock);
      if (orient_upd[3]) pulses++;
    end
    btn_four = 4'b0000;
    repeat (8) @(negedge clock);
    check("t5_gated_pulses", pulses, 0);
    check("t5_gated_in4", in4, 32'd0);
    run_press(3, 4'b0100, 10, pulses, first);
    check("t5_repress_pulses", pulses, 1);
    check("t5_repress_in4", in4, 32'd2);
    cur4 = 32'd2;

    // All four bikes accept in the same cycle
    btn_one = 4'b1000; btn_two = 4'b0010; btn_three = 4'b1000; btn_four = 4'b0010;
    upd_seen = 0; upd_cycle = 0; nz = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (orient_upd != 4'b0000) begin
        nz++;
        upd_seen = {28'd0, orient_upd};
        upd_cycle = i;
      end
    end
    btn_one = '0; btn_two = '0; btn_three = '0; btn_four = '0;
    repeat (8) @(negedge clock);
    check("all4_upd", upd_seen, 32'hF);
    check("all4_cycle", upd_cycle, 7);
    check("all4_count", nz, 1);
    check("all4_in1", in1, 32'd3);
    check("all4_in2", in2, 32'd1);
    check("all4_in3", in3, 32'd3);
    check("all4_in4", in4, 32'd1);

    // T6: two legal presses 5 and 10 cycles apart
`ifdef ORIENT_LOCKOUT_EN
    lock_pair(5, 1, 32'd2, "t6_gap5");
`else
    lock_pair(5, 2, 32'd3, "t6_gap5");
`endif
    lock_pair(10, 2, 32'd3, "t6_gap10");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
